// File: rtl/tap_buf_mc_pkg.sv
// Shared width helpers for the multi-channel tap buffer.
// Default-parameter constants are kept here; modules derive their own from the functions.
package tap_buf_mc_pkg;

  function automatic int clog2(input int v);
    int r;
    int t;
    r = 0;
    t = 1;
    while (t < v) begin
      t = t * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int cw_f(input int ch);
    return (clog2(ch) < 1) ? 1 : clog2(ch);
  endfunction

  function automatic int iw_f(input int m);
    return (clog2(m) < 1) ? 1 : clog2(m);
  endfunction

  function automatic int sw_f(input int w, input int m);
    return w + clog2(m);
  endfunction

  localparam int DEF_W  = 12;
  localparam int DEF_M  = 6;
  localparam int DEF_CH = 2;
  localparam int CW     = cw_f(DEF_CH);
  localparam int IW     = iw_f(DEF_M);
  localparam int SW     = sw_f(DEF_W, DEF_M);

endpackage

// File: rtl/tap_buf_mc_tap_chan.sv
// One channel: M-deep tap shift register, saturating fill counter and running sum.
// Next-state sum/full are exported so the top can register sum_o and sum_valid on the same edge.
module tap_chan
  import tap_buf_mc_pkg::*;
#(
  parameter int W  = 12,
  parameter int M  = 6,
  parameter int SW = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            wr_en,
  input  logic [W-1:0]    x,
  output logic [M*W-1:0]  taps_o,
  output logic [SW-1:0]   sum_next_o,
  output logic            full_next_o,
  output logic            full_o
);

  localparam int CNT_W = clog2(M + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(M);

  logic [W-1:0]     taps_q [M];
  logic [W-1:0]     taps_d [M];
  logic [SW-1:0]    sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;

  always_comb begin
    taps_d  = taps_q;
    sum_d   = sum_q;
    count_d = count_q;
    if (clr) begin
      for (int i = 0; i < M; i++) taps_d[i] = '0;
      sum_d   = '0;
      count_d = '0;
    end else if (wr_en) begin
      taps_d[0] = x;
      for (int i = 1; i < M; i++) taps_d[i] = taps_q[i-1];
      // The oldest tap leaves the window as the new sample enters it.
      sum_d = sum_q + SW'(x) - SW'(taps_q[M-1]);
      if (count_q != CNT_FULL) count_d = count_q + 1'b1;
    end
    full_d = (count_d == CNT_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < M; i++) taps_q[i] <= '0;
      sum_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      for (int i = 0; i < M; i++) taps_q[i] <= taps_d[i];
      sum_q   <= sum_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  for (genvar gi = 0; gi < M; gi++) begin : g_flat
    assign taps_o[gi*W +: W] = taps_q[gi];
  end

  assign sum_next_o  = sum_d;
  assign full_next_o = full_d;
  assign full_o      = full_q;

endmodule

// File: rtl/tap_buf_mc.sv
// Multi-channel moving-window tap buffer: per-channel shift registers with running sums,
// a registered random-access tap read port and a registered sum output stream.
module tap_buf_mc
  import tap_buf_mc_pkg::*;
#(
  parameter int W  = 12,
  parameter int M  = 6,
  parameter int CH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [cw_f(CH)-1:0]    ch,
  input  logic [W-1:0]           x,
  input  logic                   clr,
  input  logic [cw_f(CH)-1:0]    rd_ch,
  input  logic [iw_f(M)-1:0]     rd_idx,
  output logic [W-1:0]           rd_data,
  output logic [sw_f(W,M)-1:0]   sum_o,
  output logic [cw_f(CH)-1:0]    sum_ch,
  output logic                   sum_valid,
  output logic [CH-1:0]          full
);

  localparam int CH_W  = cw_f(CH);
  localparam int IDX_W = iw_f(M);
  localparam int SUM_W = sw_f(W, M);

  logic [CH-1:0]    wr_en;
  logic [M*W-1:0]   taps     [CH];
  logic [SUM_W-1:0] sum_next [CH];
  logic [CH-1:0]    full_next;

  logic [W-1:0]     rd_data_q, rd_data_d;
  logic [SUM_W-1:0] sum_o_q, sum_o_d;
  logic [CH_W-1:0]  sum_ch_q, sum_ch_d;
  logic             sum_valid_q, sum_valid_d;

  // Out-of-range channel tags match no lane, so such samples are simply dropped.
  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    assign wr_en[gi] = en && (ch == CH_W'(gi));

    tap_chan #(
      .W  (W),
      .M  (M),
      .SW (SUM_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .wr_en       (wr_en[gi]),
      .x           (x),
      .taps_o      (taps[gi]),
      .sum_next_o  (sum_next[gi]),
      .full_next_o (full_next[gi]),
      .full_o      (full[gi])
    );
  end

  // Reads see the pre-update taps; an unmatched (out-of-range) address yields zero.
  always_comb begin
    rd_data_d = '0;
    for (int c = 0; c < CH; c++) begin
      for (int i = 0; i < M; i++) begin
        if (rd_ch == CH_W'(c) && rd_idx == IDX_W'(i)) rd_data_d = taps[c][i*W +: W];
      end
    end
  end

  always_comb begin
    sum_valid_d = 1'b0;
    sum_o_d     = sum_o_q;
    sum_ch_d    = sum_ch_q;
    for (int c = 0; c < CH; c++) begin
      if (wr_en[c] && full_next[c] && !clr) begin
        sum_valid_d = 1'b1;
        sum_o_d     = sum_next[c];
        sum_ch_d    = CH_W'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q   <= '0;
      sum_o_q     <= '0;
      sum_ch_q    <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      rd_data_q   <= rd_data_d;
      sum_o_q     <= sum_o_d;
      sum_ch_q    <= sum_ch_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign sum_o     = sum_o_q;
  assign sum_ch    = sum_ch_q;
  assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_tap_buf_mc.sv
// Directed bench for tap_buf_mc at W=12, M=6, CH=3 with hand-computed expectations.
module tb_tap_buf_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  ch = '0;
  logic [11:0] x = '0;
  logic        clr = 1'b0;
  logic [1:0]  rd_ch = '0;
  logic [2:0]  rd_idx = '0;
  logic [11:0] rd_data;
  logic [14:0] sum_o;
  logic [1:0]  sum_ch;
  logic        sum_valid;
  logic [2:0]  full;

  int n_checks = 0;
  int n_errors = 0;

  tap_buf_mc #(.W(12), .M(6), .CH(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .ch        (ch),
    .x         (x),
    .clr       (clr),
    .rd_ch     (rd_ch),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .sum_o     (sum_o),
    .sum_ch    (sum_ch),
    .sum_valid (sum_valid),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c, input logic [11:0] v);
    en = 1'b1;
    ch = c;
    x  = v;
    step();
    en = 1'b0;
    $display("sample ch=%0d x=%0d -> valid=%0d sum=%0d sum_ch=%0d full=%b rd=%0d",
             c, v, sum_valid, sum_o, sum_ch, full, rd_data);
  endtask

  task automatic rd(input logic [1:0] c, input logic [2:0] i);
    rd_ch  = c;
    rd_idx = i;
    step();
    $display("read ch=%0d idx=%0d -> %0d", c, i, rd_data);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", sum_valid, 0);
    chk("rst_sum", sum_o, 0);
    chk("rst_sum_ch", sum_ch, 0);
    chk("rst_full", full, 0);
    chk("rst_rd", rd_data, 0);

    // First fill of ch0 with 100
    for (int k = 1; k <= 6; k++) begin
      send(2'd0, 12'd100);
      chk("fill0_valid", sum_valid, (k == 6) ? 1 : 0);
    end
    chk("fill0_sum", sum_o, 600);
    chk("fill0_sum_ch", sum_ch, 0);
    chk("fill0_full", full, 3'b001);

    // Max-code samples: no wrap at SW bits
    for (int j = 1; j <= 6; j++) begin
      send(2'd0, 12'd4095);
      chk("max_valid", sum_valid, 1);
      chk("max_sum", sum_o, 600 + 3995 * j);
    end
    rd(2'd0, 3'd5);
    chk("max_rd_oldest", rd_data, 4095);
    chk("hold_valid", sum_valid, 0);
    chk("hold_sum", sum_o, 24570);

    // Interleave ch1 ramp with ch0
    for (int i = 1; i <= 6; i++) begin
      send(2'd1, 12'(i));
      chk("ch1_valid", sum_valid, (i == 6) ? 1 : 0);
      if (i == 6) begin
        chk("ch1_sum", sum_o, 21);
        chk("ch1_sum_ch", sum_ch, 1);
      end
      send(2'd0, 12'd4095);
      chk("ch0_il_valid", sum_valid, 1);
      chk("ch0_il_sum", sum_o, 24570);
      chk("ch0_il_sum_ch", sum_ch, 0);
    end
    chk("il_full", full, 3'b011);
    rd(2'd1, 3'd0);
    chk("ch1_rd_newest", rd_data, 6);
    rd(2'd1, 3'd5);
    chk("ch1_rd_oldest", rd_data, 1);

    // Read and write same channel in one cycle: read returns pre-update tap
    rd_ch  = 2'd0;
    rd_idx = 3'd0;
    send(2'd0, 12'd7);
    chk("rw_pre_update", rd_data, 4095);
    chk("rw_sum", sum_o, 20482);
    rd(2'd0, 3'd0);
    chk("rw_post_update", rd_data, 7);

    // clr with simultaneous en: sample dropped, everything flushed
    clr = 1'b1;
    send(2'd0, 12'd55);
    clr = 1'b0;
    chk("clr_valid", sum_valid, 0);
    chk("clr_full", full, 0);
    chk("clr_sum_hold", sum_o, 20482);
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 6; i++) begin
        rd(2'(c), 3'(i));
        chk("clr_tap", rd_data, 0);
      end
    end
    for (int k = 1; k <= 6; k++) begin
      send(2'd0, 12'd9);
      chk("refill_valid", sum_valid, (k == 6) ? 1 : 0);
    end
    chk("refill_sum", sum_o, 54);
    chk("refill_full", full, 3'b001);

    // Out-of-range channel and read index
    rd_ch  = 2'd0;
    rd_idx = 3'd7;
    send(2'd3, 12'd123);
    chk("oor_valid", sum_valid, 0);
    chk("oor_rd", rd_data, 0);
    chk("oor_full", full, 3'b001);
    chk("oor_sum_hold", sum_o, 54);
    rd(2'd0, 3'd0);
    chk("oor_tap_kept", rd_data, 9);
    rd(2'd3, 3'd0);
    chk("oor_rd_ch", rd_data, 0);

    // Reset mid-fill on ch2
    for (int k = 0; k < 3; k++) send(2'd2, 12'd10);
    chk("mid_valid", sum_valid, 0);
    rd_ch  = 2'd0;
    rd_idx = 3'd0;
    step();
    chk("pre_rst_rd", rd_data, 9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_valid", sum_valid, 0);
    chk("rst2_sum", sum_o, 0);
    chk("rst2_sum_ch", sum_ch, 0);
    chk("rst2_full", full, 0);
    chk("rst2_rd", rd_data, 0);
    rd(2'd0, 3'd0);
    chk("rst2_tap", rd_data, 0);
    for (int k = 1; k <= 6; k++) begin
      send(2'd2, 12'd10);
      chk("ch2_valid", sum_valid, (k == 6) ? 1 : 0);
    end
    chk("ch2_sum", sum_o, 60);
    chk("ch2_sum_ch", sum_ch, 2);
    chk("ch2_full", full, 3'b100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
